// File: rtl/sm4_pkg.sv
// Shared SM4 constants, transforms and key-schedule FSM state type.
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK[i] byte j = (4*i + j) * 7 mod 256
  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  function automatic logic [31:0] sm4_tau(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Key-schedule linear transform: b ^ (b<<<13) ^ (b<<<23)
  function automatic logic [31:0] sm4_lk(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Cipher linear transform, kept here so the round datapath shares one definition
  function automatic logic [31:0] sm4_le(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

endpackage

// File: rtl/sm4_ks_round.sv
// One combinational SM4 key-expansion step: rk = K0 ^ L'(tau(K1^K2^K3^CK)).
module sm4_ks_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] ck,
  output logic [31:0] rk
);

  logic [31:0] mix;
  logic [31:0] subst;

  assign mix   = k1 ^ k2 ^ k3 ^ ck;
  assign subst = sm4_tau(mix);
  assign rk    = k0 ^ sm4_lk(subst);

endmodule

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key expansion, one round key per clock, 32-word register file.
// Optional macro SM4_KS_DEC_ORDER_EN adds rd_dec for reversed (decrypt-order) reads.
module sm4_key_sched
  import sm4_pkg::*;
#(
  parameter int NROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mk_valid,
  output logic         mk_ready,
  input  logic [127:0] mk,
  output logic         busy,
  output logic         key_valid,
  output logic         rk_stb,
  output logic [4:0]   rk_idx,
  output logic [31:0]  rk_word,
  input  logic [4:0]   rd_addr,
`ifdef SM4_KS_DEC_ORDER_EN
  input  logic         rd_dec,
`endif
  output logic [31:0]  rd_data
);

  if (NROUNDS != 32) begin : g_bad_nrounds
    $error("sm4_key_sched: NROUNDS must be 32");
  end

  ks_state_t   state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] k_q [4];
  logic [31:0] rk_mem [32];
  logic [31:0] rk_next;
  logic        accept;
  logic        last_round;
  logic [4:0]  eff_addr;

  assign mk_ready   = (state_q != ST_EXPAND);
  assign busy       = (state_q == ST_EXPAND);
  assign key_valid  = (state_q == ST_DONE);
  assign accept     = mk_valid && mk_ready;
  assign last_round = (cnt_q == 5'd31);

  sm4_ks_round u_round (
    .k0 (k_q[0]),
    .k1 (k_q[1]),
    .k2 (k_q[2]),
    .k3 (k_q[3]),
    .ck (CK[cnt_q]),
    .rk (rk_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_EXPAND;
      ST_EXPAND: if (last_round) state_d = ST_DONE;
      ST_DONE:   if (accept) state_d = ST_EXPAND;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Accept can only occur outside EXPAND, so load and shift never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rk_stb  <= 1'b0;
      rk_idx  <= '0;
      rk_word <= '0;
      for (int i = 0; i < 4; i++) begin
        k_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        rk_mem[i] <= '0;
      end
    end else begin
      rk_stb <= 1'b0;
      if (accept) begin
        k_q[0] <= mk[127:96] ^ FK[0];
        k_q[1] <= mk[95:64]  ^ FK[1];
        k_q[2] <= mk[63:32]  ^ FK[2];
        k_q[3] <= mk[31:0]   ^ FK[3];
        cnt_q  <= '0;
      end else if (state_q == ST_EXPAND) begin
        rk_mem[cnt_q] <= rk_next;
        k_q[0]  <= k_q[1];
        k_q[1]  <= k_q[2];
        k_q[2]  <= k_q[3];
        k_q[3]  <= rk_next;
        rk_stb  <= 1'b1;
        rk_idx  <= cnt_q;
        rk_word <= rk_next;
        cnt_q   <= cnt_q + 5'd1;
      end
    end
  end

`ifdef SM4_KS_DEC_ORDER_EN
  assign eff_addr = rd_dec ? (5'd31 - rd_addr) : rd_addr;
`else
  assign eff_addr = rd_addr;
`endif

  // Partially expanded keys stay hidden behind key_valid.
  always_comb begin
    rd_data = 32'h0;
    if (key_valid) begin
      rd_data = rk_mem[eff_addr];
    end
  end

endmodule

// File: tb/tb_sm4_key_sched.sv
// Directed self-checking bench for sm4_key_sched using the standard SM4 vector.
// Defining SM4_KS_DEC_ORDER_EN also exercises the reversed read port.
module tb_sm4_key_sched;

  localparam logic [127:0] STD_KEY  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [31:0]  STD_RK0  = 32'hf12186f9;
  localparam logic [31:0]  STD_RK1  = 32'h41662b61;
  localparam logic [31:0]  STD_RK31 = 32'h9124a012;
  localparam logic [31:0]  ZERO_RK0 = 32'h45603b23;

  logic         clk;
  logic         rst;
  logic         mk_valid;
  logic         mk_ready;
  logic [127:0] mk;
  logic         busy;
  logic         key_valid;
  logic         rk_stb;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_word;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;
`ifdef SM4_KS_DEC_ORDER_EN
  logic         rd_dec;
`endif

  int checks = 0;
  int errors = 0;

  sm4_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .mk_valid  (mk_valid),
    .mk_ready  (mk_ready),
    .mk        (mk),
    .busy      (busy),
    .key_valid (key_valid),
    .rk_stb    (rk_stb),
    .rk_idx    (rk_idx),
    .rk_word   (rk_word),
    .rd_addr   (rd_addr),
`ifdef SM4_KS_DEC_ORDER_EN
    .rd_dec    (rd_dec),
`endif
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [127:0] key, input logic valid);
    mk       = key;
    mk_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    mk_valid = 1'b0;
    mk       = '0;
    rd_addr  = '0;
`ifdef SM4_KS_DEC_ORDER_EN
    rd_dec   = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_mk_ready", mk_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_rk_stb", rk_stb, 0);
    checkOutput("rst_rk_idx", rk_idx, 0);
    checkOutput("rst_rk_word", rk_word, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] standard key expansion");
    applyStimulus(STD_KEY, 1'b1);
    @(posedge clk);
    #1;
    mk_valid = 1'b0;
    checkOutput("std_busy_after_accept", busy, 1);
    checkOutput("std_ready_after_accept", mk_ready, 0);
    checkOutput("std_no_stb_at_accept", rk_stb, 0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("std_stb_%0d", i), rk_stb, 1);
      checkOutput($sformatf("std_idx_%0d", i), rk_idx, i);
      if (i == 0) checkOutput("std_rk0", rk_word, STD_RK0);
      if (i == 1) checkOutput("std_rk1", rk_word, STD_RK1);
      if (i == 31) begin
        checkOutput("std_rk31", rk_word, STD_RK31);
        checkOutput("std_key_valid_edge32", key_valid, 1);
        checkOutput("std_busy_edge32", busy, 0);
        checkOutput("std_rd_rk0", rd_data, STD_RK0);
      end else begin
        checkOutput($sformatf("std_kv_low_%0d", i), key_valid, 0);
        checkOutput($sformatf("std_rd_hidden_%0d", i), rd_data, 0);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("std_no_stb_done", rk_stb, 0);
    checkOutput("std_idx_hold", rk_idx, 31);
    rd_addr = 5'd1;
    #1;
    checkOutput("std_rd_rk1", rd_data, STD_RK1);
    rd_addr = 5'd31;
    #1;
    checkOutput("std_rd_rk31", rd_data, STD_RK31);

`ifdef SM4_KS_DEC_ORDER_EN
    $display("[TB] decrypt-order reads");
    rd_dec  = 1'b1;
    rd_addr = 5'd0;
    #1;
    checkOutput("dec_rd_addr0", rd_data, STD_RK31);
    rd_addr = 5'd31;
    #1;
    checkOutput("dec_rd_addr31", rd_data, STD_RK0);
    rd_addr = 5'd30;
    #1;
    checkOutput("dec_rd_addr30", rd_data, STD_RK1);
    rd_dec  = 1'b0;
`endif

    $display("[TB] handshake with held mk_valid");
    rd_addr = 5'd0;
    applyStimulus(STD_KEY, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("hs_kv_drop_on_accept", key_valid, 0);
    checkOutput("hs_busy", busy, 1);
    checkOutput("hs_rd_hidden", rd_data, 0);
    applyStimulus(ZERO_KEY, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hs_idx_%0d", i), rk_idx, i);
      if (i < 31) begin
        checkOutput($sformatf("hs_ready_low_%0d", i), mk_ready, 0);
      end else begin
        checkOutput("hs_ready_high", mk_ready, 1);
        checkOutput("hs_key_valid", key_valid, 1);
        checkOutput("hs_rk31", rk_word, STD_RK31);
        checkOutput("hs_rd_rk0", rd_data, STD_RK0);
      end
    end
    @(posedge clk);
    #1;
    mk_valid = 1'b0;
    checkOutput("hs2_kv_drop", key_valid, 0);
    checkOutput("hs2_busy", busy, 1);
    checkOutput("hs2_rd_zero", rd_data, 0);
    checkOutput("hs2_no_stb_accept", rk_stb, 0);

    $display("[TB] all-zero key expansion");
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("zero_stb_%0d", i), rk_stb, 1);
      checkOutput($sformatf("zero_idx_%0d", i), rk_idx, i);
      if (i == 0) checkOutput("zero_rk0", rk_word, ZERO_RK0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("zero_done_no_stb_%0d", i), rk_stb, 0);
      checkOutput($sformatf("zero_done_kv_%0d", i), key_valid, 1);
    end
    checkOutput("zero_rd_rk0", rd_data, ZERO_RK0);

    $display("[TB] reset mid-expansion");
    applyStimulus(STD_KEY, 1'b1);
    @(posedge clk);
    #1;
    mk_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_mk_ready", mk_ready, 1);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_key_valid", key_valid, 0);
    checkOutput("mid_rst_rk_stb", rk_stb, 0);
    checkOutput("mid_rst_rk_idx", rk_idx, 0);
    checkOutput("mid_rst_rk_word", rk_word, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_idle_ready", mk_ready, 1);
    checkOutput("post_rst_idle_busy", busy, 0);
    applyStimulus(ZERO_KEY, 1'b1);
    @(posedge clk);
    #1;
    mk_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_addr = 5'd0;
    #1;
    checkOutput("post_rst_rd_hidden", rd_data, 0);
    checkOutput("post_rst_kv_low", key_valid, 0);
    checkOutput("post_rst_idx", rk_idx, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_key_sched.md
Name: sm4_key_sched

Overview:
Iterative SM4 key-expansion engine. Accepts a 128-bit master key through a valid/ready handshake and computes one round key per clock (32 cycles). It stores all 32 round keys in an internal register file and exposes them through an asynchronous read port, plus a per-round strobe. It sits directly upstream of the SM4 round/cipher datapath and replaces the fully unrolled combinational key generator with a small sequential unit.

Parameters:
- NROUNDS, 32, number of round keys generated; fixed by the SM4 standard; RTL asserts NROUNDS == 32.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Asynchronous, active-high reset.
- mk_valid  in  1  Master key offered.
- mk_ready  out  1  Engine can accept a key.
- mk  in  128  Master key; byte 0 at [127:120], big-endian word order (MK0 = mk[127:96]).
- busy  out  1  Expansion in progress.
- key_valid  out  1  All 32 round keys stored and stable.
- rk_stb  out  1  One-cycle pulse: rk_word/rk_idx carry a freshly computed key.
- rk_idx  out  5  Index of rk_word.
- rk_word  out  32  Round key just computed.
- rd_addr  in  5  Register-file read address.
- rd_data  out  32  rk[rd_addr], combinational.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; mk_ready=1; busy=0; key_valid=0; rk_stb=0; rk_idx=0; rk_word=0; round counter=0; K shift register=0; all 32 storage words=0.
- FSM states:
  - IDLE: no key loaded.
  - EXPAND: computing.
  - DONE: keys valid.
- mk_ready = (state != EXPAND). busy = (state == EXPAND). key_valid = (state == DONE).
- Accept occurs on a rising edge with mk_valid && mk_ready. Effects:
  - Load K0..K3 = MKi ^ FKi, where FK = a3b1bac6, 56aa3350, 677d9197, b27022dc.
  - Clear the counter.
  - Go to EXPAND.
  - If accepted in DONE, key_valid drops on that same edge.
- Each EXPAND cycle, with i = counter:
  - a = K1^K2^K3^CK[i].
  - b = four parallel S-box lookups on a.
  - rk = K0 ^ b ^ (b<<<13) ^ (b<<<23).
  - Store rk at index i. Shift K0<=K1, K1<=K2, K2<=K3, K3<=rk.
  - Register rk_stb=1, rk_idx=i, rk_word=rk. Increment the counter.
- Counter wrap: when i==31 the cycle writes rk31 and transitions to DONE. The 5-bit counter wraps to 0 and is not used again until the next accept.
- Latency: accept on edge 0. rk_i is stored and strobed after edge i+1. key_valid is high after edge 32. Back-to-back keys: the next accept is possible from the cycle key_valid rises, giving 33 cycles/key.
- mk_valid during EXPAND is ignored (not accepted). The offerer holds mk until accepted.
- rd_data = key_valid ? rk_mem[rd_addr] : 32'h0. Partial keys are never visible on the read port; the rk_stb stream is the only early view.
- rk_stb is 0 in IDLE/DONE. rk_idx and rk_word hold their last values.
- Reset asserted mid-EXPAND aborts immediately. All storage is cleared, and no partial keys survive.

Optional Feature:
- Macro: SM4_KS_DEC_ORDER_EN.
- Defined:
  - Adds input port rd_dec (1 bit).
  - When rd_dec=1, rd_data = rk_mem[31 - rd_addr], so the decrypt datapath reads keys with the same ascending address sequence as encrypt.
  - key_valid gating still applies.
- Undefined: no rd_dec port; rd_data always uses rd_addr directly.

Decomposition:
- Package sm4_pkg contains:
  - SBOX[256] constant.
  - CK[32] constant.
  - FK[4] constant.
  - Function sm4_tau(word) (4-byte S-box substitution).
  - Functions sm4_lk(word) (key linear transform) and sm4_le(word) (cipher linear transform, for sharing with the round datapath).
  - FSM state typedef (IDLE, EXPAND, DONE).
- One sub-module: sm4_ks_round.
  - Combinational: inputs K0..K3 and CK word; output rk.
  - Used once per cycle by sm4_key_sched.

Test Plan:
- Standard vector: mk=0123456789abcdeffedcba9876543210 -> rk_stb pulses 32 consecutive cycles. rk0=f12186f9, rk1=41662b61, rk31=9124a012. key_valid after edge 32. rd_addr=31 gives 9124a012.
- Handshake: hold mk_valid through EXPAND with a second key -> mk_ready=0 for 32 cycles, no accept. Second key accepted the cycle key_valid rises. key_valid drops next edge, and rd_data reads 0 until re-expansion completes.
- Reset mid-op: assert rst at round 10 -> all outputs return to reset values asynchronously. rd_addr=0 gives 0 after a new key is accepted and not yet done.
- All-zero key: mk=0 -> 32 strobes with rk_idx 0..31 in order. Stored words match a reference model. No strobe in DONE.
- SM4_KS_DEC_ORDER_EN: standard key, rd_dec=1, rd_addr=0 -> 9124a012; rd_addr=31 -> f12186f9.
